// File: rtl/freq_meter_pkg.sv
// Shared BCD types and the single-digit increment helper used by the frequency meter.
package freq_meter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  typedef struct packed {
    logic       carry;
    bcd_digit_t digit;
  } bcd_inc_t;

  // One decade step: a digit at 9 with carry-in wraps to 0 and carries out.
  function automatic bcd_inc_t bcd_inc(input bcd_digit_t digit, input logic carry_in);
    bcd_inc_t res;
    if (!carry_in) begin
      res.carry = 1'b0;
      res.digit = digit;
    end else if (digit >= BCD_MAX_DIGIT) begin
      res.carry = 1'b1;
      res.digit = 4'd0;
    end else begin
      res.carry = 1'b0;
      res.digit = digit + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/freq_meter_bcd_counter.sv
// Saturating N-digit BCD event counter with sticky overflow; CLR wins over INC.
module bcd_counter
  import freq_meter_pkg::*;
#(
  parameter int N_DIGITS = 6
) (
  input  logic                  PCK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  INC,
  output logic [4*N_DIGITS-1:0] COUNT,
  output logic                  OVF
);

  localparam int W = 4 * N_DIGITS;
  localparam logic [W-1:0] ALL_NINES = {N_DIGITS{BCD_MAX_DIGIT}};

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;

  // Ripple-carry increment; a carry out of the top digit pins the count at all 9s.
  always_comb begin : next_count
    logic     carry;
    bcd_inc_t step;
    carry   = INC;
    count_d = count_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      step               = bcd_inc(count_q[4*i +: 4], carry);
      count_d[4*i +: 4]  = step.digit;
      carry              = step.carry;
    end
    if (CLR) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (carry) begin
      count_d = ALL_NINES;
      ovf_d   = 1'b1;
    end else begin
      ovf_d   = ovf_q;
    end
  end

  // Count and overflow state.
  always_ff @(posedge PCK) begin
    if (RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign COUNT = count_q;
  assign OVF   = ovf_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over an fPck-cycle gate window
// and publishes the result as packed BCD with a one-cycle VALID strobe.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int fPck     = 25174825,
  parameter int N_DIGITS = 6
) (
  input  logic                  PCK,
  input  logic                  RST,
  input  logic                  SIG_IN,
  output logic [4*N_DIGITS-1:0] FREQ_BCD,
  output logic                  OVERFLOW,
  output logic                  VALID
);

  localparam int W  = 4 * N_DIGITS;
  localparam int TW = $clog2(fPck);
  localparam logic [TW-1:0] TERMINAL  = TW'(fPck - 1);
  localparam logic [W-1:0]  ALL_NINES = {N_DIGITS{BCD_MAX_DIGIT}};

  logic          s1_q, s2_q, s3_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  freq_q, freq_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic          edge_s, term_s;
  logic [W-1:0]  live_cnt_s;
  logic          live_ovf_s;

  assign edge_s = s2_q & ~s3_q;
  assign term_s = (timer_q == TERMINAL);

  bcd_counter #(
    .N_DIGITS(N_DIGITS)
  ) u_cnt (
    .PCK  (PCK),
    .RST  (RST),
    .CLR  (term_s),
    .INC  (edge_s),
    .COUNT(live_cnt_s),
    .OVF  (live_ovf_s)
  );

  // An edge on the terminal cycle still belongs to the closing window, so the
  // published value is the live count with that edge folded in.
  always_comb begin : next_state
    logic        carry;
    bcd_inc_t    step;
    logic [W-1:0] close_cnt;
    carry     = edge_s;
    close_cnt = live_cnt_s;
    for (int i = 0; i < N_DIGITS; i++) begin
      step                = bcd_inc(live_cnt_s[4*i +: 4], carry);
      close_cnt[4*i +: 4] = step.digit;
      carry               = step.carry;
    end
    if (carry) begin
      close_cnt = ALL_NINES;
    end else begin
      close_cnt = close_cnt;
    end
    timer_d = timer_q + TW'(1);
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (term_s) begin
      timer_d = '0;
      freq_d  = close_cnt;
      ovf_d   = live_ovf_s | carry;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Synchronizer, edge history, gate timer and published result.
  always_ff @(posedge PCK) begin
    if (RST) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      timer_q <= '0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= SIG_IN;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      timer_q <= timer_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign FREQ_BCD = freq_q;
  assign OVERFLOW = ovf_q;
  assign VALID    = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: three configurations share one input and are checked
// every cycle against an integer edge-count model of the gate window.
module tb_freq_meter;

  logic pck = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;

  always #5 pck = ~pck;

  logic [23:0] freq_a;
  logic        ovf_a, val_a;
  logic [11:0] freq_b;
  logic        ovf_b, val_b;
  logic [3:0]  freq_c;
  logic        ovf_c, val_c;

  freq_meter #(.fPck(100), .N_DIGITS(6)) u_a (
    .PCK(pck), .RST(rst), .SIG_IN(sig), .FREQ_BCD(freq_a), .OVERFLOW(ovf_a), .VALID(val_a));
  freq_meter #(.fPck(400), .N_DIGITS(3)) u_b (
    .PCK(pck), .RST(rst), .SIG_IN(sig), .FREQ_BCD(freq_b), .OVERFLOW(ovf_b), .VALID(val_b));
  freq_meter #(.fPck(100), .N_DIGITS(1)) u_c (
    .PCK(pck), .RST(rst), .SIG_IN(sig), .FREQ_BCD(freq_c), .OVERFLOW(ovf_c), .VALID(val_c));

  int total = 0;
  int bad   = 0;

  // Reference model state, one slot per configuration.
  int          fp [3] = '{100, 400, 100};
  int          nd [3] = '{6, 3, 1};
  int          n_m [3];
  int          cnt_m [3];
  logic [31:0] exp_freq [3];
  logic        exp_ovf [3];
  logic        exp_valid [3];
  logic [3:0]  hist;   // hist[0] = SIG_IN seen at the most recent clock edge

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dec_limit(input int digits);
    int lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    return lim - 1;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int digits);
    logic [31:0] r = 32'd0;
    int          x = v;
    if (x > dec_limit(digits)) x = dec_limit(digits);
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // An input rise sampled at edge j is counted at edge j+2 (sampled history
  // cleared by reset); every fPck-th edge closes a window.
  task automatic model_step();
    logic e;
    if (rst) begin
      hist = 4'd0;
      for (int k = 0; k < 3; k++) begin
        n_m[k] = 0; cnt_m[k] = 0;
        exp_freq[k] = 32'd0; exp_ovf[k] = 1'b0; exp_valid[k] = 1'b0;
      end
    end else begin
      e    = hist[1] & ~hist[2];
      hist = {hist[2:0], sig};
      for (int k = 0; k < 3; k++) begin
        if (e) cnt_m[k] = cnt_m[k] + 1;
        if ((n_m[k] % fp[k]) == fp[k] - 1) begin
          exp_valid[k] = 1'b1;
          exp_freq[k]  = to_bcd(cnt_m[k], nd[k]);
          exp_ovf[k]   = (cnt_m[k] > dec_limit(nd[k]));
          cnt_m[k]     = 0;
        end else begin
          exp_valid[k] = 1'b0;
        end
        n_m[k] = n_m[k] + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("a_valid", 32'(val_a), 32'(exp_valid[0]));
    check("a_freq",  32'(freq_a), exp_freq[0]);
    check("a_ovf",   32'(ovf_a), 32'(exp_ovf[0]));
    check("a_live",  32'(u_a.u_cnt.COUNT), to_bcd(cnt_m[0], 6));
    check("b_valid", 32'(val_b), 32'(exp_valid[1]));
    check("b_freq",  32'(freq_b), exp_freq[1]);
    check("b_ovf",   32'(ovf_b), 32'(exp_ovf[1]));
    check("b_live",  32'(u_b.u_cnt.COUNT), to_bcd(cnt_m[1], 3));
    check("c_valid", 32'(val_c), 32'(exp_valid[2]));
    check("c_freq",  32'(freq_c), exp_freq[2]);
    check("c_ovf",   32'(ovf_c), 32'(exp_ovf[2]));
    check("c_live_ovf", 32'(u_c.u_cnt.OVF), 32'(cnt_m[2] > 9));
  endtask

  task automatic tick(input logic s, input logic r);
    @(negedge pck);
    sig = s;
    rst = r;
    @(posedge pck);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    repeat (cycles) tick(1'b0, 1'b1);
  endtask

  initial begin
    int hi, lo, c;

    do_reset(3);
    check("rst_freq_a", 32'(freq_a), 32'd0);
    check("rst_valid_a", 32'(val_a), 32'd0);
    check("rst_ovf_c", 32'(ovf_c), 32'd0);

    // Period 10, first rise 5 cycles after release.
    for (int i = 0; i < 300; i++) begin
      tick(i >= 5 && ((i - 5) % 10) < 5, 1'b0);
      if (i == 99 || i == 199) begin
        check("p10_valid", 32'(val_a), 32'd1);
        check("p10_freq", 32'(freq_a), 32'h10);
        check("p10_ovf", 32'(ovf_a), 32'd0);
      end
    end

    // Held low, then a single rise, then held high.
    do_reset(2);
    for (int i = 0; i < 500; i++) begin
      tick(i >= 250, 1'b0);
      if (i == 99 || i == 199 || i == 399 || i == 499) begin
        check("hold_valid", 32'(val_a), 32'd1);
        check("hold_freq", 32'(freq_a), 32'd0);
      end
    end

    // Period 4: 100 per 400-cycle window, 25 per 100 cycles, then stopped.
    do_reset(2);
    for (int i = 0; i < 500; i++) begin
      tick(i < 400 && (i % 4) < 2, 1'b0);
      if (i == 99) begin
        check("p4_c_freq", 32'(freq_c), 32'h9);
        check("p4_c_ovf", 32'(ovf_c), 32'd1);
        check("p4_a_freq", 32'(freq_a), 32'h25);
      end
      if (i == 394) check("p4_b_live99", 32'(u_b.u_cnt.COUNT), 32'h099);
      if (i == 398) check("p4_b_live100", 32'(u_b.u_cnt.COUNT), 32'h100);
      if (i == 399) begin
        check("p4_b_valid", 32'(val_b), 32'd1);
        check("p4_b_freq", 32'(freq_b), 32'h100);
        check("p4_b_ovf", 32'(ovf_b), 32'd0);
      end
      if (i == 499) begin
        check("stop_c_freq", 32'(freq_c), 32'h0);
        check("stop_c_ovf", 32'(ovf_c), 32'd0);
      end
    end

    // One counted edge landing exactly on the terminal cycle.
    do_reset(2);
    for (int i = 0; i < 200; i++) begin
      tick((i >= 5 && i < 90 && ((i - 5) % 10) < 5) || (i >= 97 && i <= 101), 1'b0);
      if (i == 99) begin
        check("term_a_freq", 32'(freq_a), 32'h10);
        check("term_c_ovf", 32'(ovf_c), 32'd1);
      end
      if (i == 100) check("term_a_live", 32'(u_a.u_cnt.COUNT), 32'h0);
      if (i == 199) check("term_next_freq", 32'(freq_a), 32'h0);
    end

    // One-cycle reset in the middle of the second window.
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      tick(i >= 5 && ((i - 5) % 10) < 5, i == 150);
      if (i == 150) begin
        check("mid_rst_freq", 32'(freq_a), 32'd0);
        check("mid_rst_valid", 32'(val_a), 32'd0);
      end
      if (i == 199) check("mid_rst_novalid", 32'(val_a), 32'd0);
      if (i == 250) begin
        check("mid_rst_valid2", 32'(val_a), 32'd1);
        check("mid_rst_freq2", 32'(freq_a), 32'h10);
      end
    end

    // Random pulse trains, including widths too short to be counted reliably.
    do_reset(2);
    c = 0;
    while (c < 1600) begin
      hi = $urandom_range(1, 6);
      lo = $urandom_range(1, 6);
      repeat (hi) tick(1'b1, 1'b0);
      repeat (lo) tick(1'b0, ($urandom_range(0, 199) == 0));
      c = c + hi + lo;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
